ring_osc_trim_cal: RTL and testbench

//  Calibrates the 26-bit trim of the 13-stage ring oscillator (ring_osc2x13) against a reference clock.

---
 rtl/ring_osc_cal_pkg.sv | 31 +++
 rtl/ring_osc_freq_counter.sv | 43 ++++
 rtl/ring_osc_trim_cal.sv | 175 +++++++++++++++++
 tb/tb_ring_osc_trim_cal.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_osc_cal_pkg.sv
// Shared definitions for the ring oscillator trim calibrator: FSM state codes,
// code range limits and the code-to-trim thermometer decode.
package ring_osc_cal_pkg;

    localparam int MAX_CODE = 26;
    localparam int N_STAGES = 13;
    localparam int TRIM_W   = 2 * N_STAGES;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SAR_SET = 3'd1;
    localparam state_t ST_APPLY   = 3'd2;
    localparam state_t ST_MEASURE = 3'd3;
    localparam state_t ST_EVAL    = 3'd4;
    localparam state_t ST_FINAL   = 3'd5;
    localparam state_t ST_DONE    = 3'd6;

    // Code n enables the lowest n trim bits; the first 13 load the fine half of
    // the ring, codes above 13 continue into the second half. Codes >26 clamp.
    function automatic logic [TRIM_W-1:0] trim_decode(input logic [4:0] code);
        logic [TRIM_W-1:0] t;
        int n;
        n = (int'(code) > MAX_CODE) ? MAX_CODE : int'(code);
        for (int i = 0; i < TRIM_W; i++) begin
            t[i] = (i < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/ring_osc_freq_counter.sv
// Counts both edges of an asynchronous, pre-divided oscillator signal after a
// multi-flop synchronizer; the count saturates at all-ones.
module ring_osc_freq_counter #(
    parameter int CW   = 16,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic          async_in,
    output logic [CW-1:0] count
);

    logic [SYNC-1:0] sync_reg;
    logic            prev_reg;
    logic [CW-1:0]   count_reg;
    logic            edge_det;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC-2:0], async_in};
            prev_reg <= sync_reg[SYNC-1];
        end
    end

    // Only the last two synchronized samples take part in edge detection.
    assign edge_det = sync_reg[SYNC-1] ^ prev_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && edge_det && (count_reg != {CW{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/ring_osc_trim_cal.sv
// Successive-approximation trim calibration of the 13-stage ring oscillator:
// finds the slowest code whose measured edge count still meets the target.
module ring_osc_trim_cal
    import ring_osc_cal_pkg::*;
#(
    parameter int WINDOW = 1024,
    parameter int SETTLE = 64,
    parameter int CW     = 16,
    parameter int SYNC   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CW-1:0]     target,
    input  logic              osc_div_in,
    input  logic              manual_en,
    input  logic [4:0]        manual_code,
    output logic [TRIM_W-1:0] trim,
    output logic              osc_reset,
    output logic              busy,
    output logic              done,
    output logic [4:0]        code,
    output logic [CW-1:0]     meas_count,
    output logic              cal_err
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    state_t            state_reg;
    logic [2:0]        bit_reg;
    logic [4:0]        res_reg;
    logic [4:0]        trial_reg;
    logic              final_reg;
    logic [CW-1:0]     target_reg;
    logic [TW-1:0]     timer_reg;
    logic [TRIM_W-1:0] trim_reg;
    logic              osc_reset_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [4:0]        code_reg;
    logic [CW-1:0]     meas_reg;
    logic              err_reg;

    logic [4:0]        trial;
    logic [CW-1:0]     count;

    assign trial = res_reg | (5'd1 << bit_reg);

    ring_osc_freq_counter #(
        .CW   (CW),
        .SYNC (SYNC)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_reg == ST_APPLY),
        .enable   (state_reg == ST_MEASURE),
        .async_in (osc_div_in),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bit_reg       <= 3'd0;
            res_reg       <= 5'd0;
            trial_reg     <= 5'd0;
            final_reg     <= 1'b0;
            target_reg    <= '0;
            timer_reg     <= '0;
            trim_reg      <= '0;
            osc_reset_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            code_reg      <= 5'd0;
            meas_reg      <= '0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (manual_en) begin
                        trim_reg      <= trim_decode(manual_code);
                        osc_reset_reg <= 1'b0;
                    end else if (start) begin
                        osc_reset_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        target_reg    <= target;
                        res_reg       <= 5'd0;
                        bit_reg       <= 3'd4;
                        final_reg     <= 1'b0;
                        state_reg     <= ST_SAR_SET;
                    end else begin
                        trim_reg <= trim_decode(code_reg);
                    end
                end
                ST_SAR_SET: begin
                    // Out-of-range trials are rejected without a measurement.
                    if (trial > 5'(MAX_CODE)) begin
                        if (bit_reg == 3'd0) begin
                            state_reg <= ST_FINAL;
                        end else begin
                            bit_reg <= bit_reg - 3'd1;
                        end
                    end else begin
                        trial_reg <= trial;
                        trim_reg  <= trim_decode(trial);
                        timer_reg <= '0;
                        state_reg <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (timer_reg == TW'(SETTLE - 1)) begin
                        timer_reg <= '0;
                        state_reg <= ST_MEASURE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (timer_reg == TW'(WINDOW - 1)) begin
                        timer_reg <= '0;
                        state_reg <= ST_EVAL;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (final_reg) begin
                        code_reg  <= res_reg;
                        meas_reg  <= count;
                        err_reg   <= (count < target_reg);
                        trim_reg  <= trim_decode(res_reg);
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        if (count >= target_reg) begin
                            res_reg <= trial_reg;
                        end
                        if (bit_reg == 3'd0) begin
                            state_reg <= ST_FINAL;
                        end else begin
                            bit_reg   <= bit_reg - 3'd1;
                            state_reg <= ST_SAR_SET;
                        end
                    end
                end
                ST_FINAL: begin
                    // Re-measure at the chosen code so meas_count reflects it.
                    trim_reg  <= trim_decode(res_reg);
                    final_reg <= 1'b1;
                    timer_reg <= '0;
                    state_reg <= ST_APPLY;
                end
                ST_DONE: begin
                    trim_reg  <= trim_decode(code_reg);
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign trim       = trim_reg;
    assign osc_reset  = osc_reset_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign code       = code_reg;
    assign meas_count = meas_reg;
    assign cal_err    = err_reg;

endmodule

// File: tb/tb_ring_osc_trim_cal.sv
// Scoreboard bench: a behavioural oscillator (edges/window = 200 - 6*code) feeds
// the calibrator; expected results come from a plain search over all codes.
`timescale 1ns/1ps
module tb_ring_osc_trim_cal;

    localparam int CW     = 16;
    localparam int WINDOW = 512;
    localparam int SETTLE = 32;
    localparam int SYNC   = 2;
    localparam int BUDGET = 8000;

    typedef struct {
        int code;
        int count;
        bit err;
        int cycles;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] target = '0;
    logic          osc_div_in = 1'b0;
    logic          manual_en = 1'b0;
    logic [4:0]    manual_code = 5'd0;
    logic [25:0]   trim;
    logic          osc_reset;
    logic          busy;
    logic          done;
    logic [4:0]    code;
    logic [CW-1:0] meas_count;
    logic          cal_err;

    // Saturation instance: 8-bit count, fed a fixed clk/3 signal.
    logic          s_reset = 1'b1;
    logic          s_start = 1'b0;
    logic [7:0]    s_target = 8'd0;
    logic          s_osc = 1'b0;
    logic [25:0]   s_trim;
    logic          s_osc_reset;
    logic          s_busy;
    logic          s_done;
    logic [4:0]    s_code;
    logic [7:0]    s_meas;
    logic          s_err;

    int   n_pass = 0;
    int   n_total = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ring_osc_trim_cal #(.WINDOW(WINDOW), .SETTLE(SETTLE), .CW(CW), .SYNC(SYNC)) dut (
        .clk(clk), .reset(reset), .start(start), .target(target),
        .osc_div_in(osc_div_in), .manual_en(manual_en), .manual_code(manual_code),
        .trim(trim), .osc_reset(osc_reset), .busy(busy), .done(done),
        .code(code), .meas_count(meas_count), .cal_err(cal_err)
    );

    ring_osc_trim_cal #(.WINDOW(512), .SETTLE(8), .CW(8), .SYNC(3)) dut_sat (
        .clk(clk), .reset(s_reset), .start(s_start), .target(s_target),
        .osc_div_in(s_osc), .manual_en(1'b0), .manual_code(5'd0),
        .trim(s_trim), .osc_reset(s_osc_reset), .busy(s_busy), .done(s_done),
        .code(s_code), .meas_count(s_meas), .cal_err(s_err)
    );

    function automatic int edges_at(int c);
        return 200 - 6 * c;
    endfunction

    function automatic logic [25:0] therm(int n);
        logic [63:0] v;
        v = (64'd1 << n) - 64'd1;
        return v[25:0];
    endfunction

    // Expected outcome: best code by exhaustive search, busy length by walking
    // the five SAR trials (measured trials cost SETTLE+WINDOW+2, skips 1).
    function automatic exp_t model(int tgt);
        exp_t e;
        int best = 0;
        int res = 0;
        int cyc = 0;
        for (int c = 0; c <= 26; c++) begin
            if (edges_at(c) >= tgt) best = c;
        end
        for (int b = 4; b >= 0; b--) begin
            int t;
            t = res | (1 << b);
            if (t > 26) begin
                cyc += 1;
            end else begin
                cyc += SETTLE + WINDOW + 2;
                if (edges_at(t) >= tgt) res = t;
            end
        end
        cyc += SETTLE + WINDOW + 2;
        e.code   = best;
        e.count  = edges_at(best);
        e.err    = (edges_at(best) < tgt);
        e.cycles = cyc;
        return e;
    endfunction

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Oscillator frequency follows the thermometer code currently on trim.
    initial begin
        forever begin
            realtime hp;
            hp = 5120.0 / real'(edges_at($countones(trim)));
            #(hp) osc_div_in = ~osc_div_in;
        end
    end

    initial forever #15 s_osc = ~s_osc;

    // Monitor: pops one expectation per done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1'b0, 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("code", code == 5'(e.code), code, e.code);
                        check("cal_err", cal_err == e.err, cal_err, e.err);
                        check("meas_count", (int'(meas_count) >= e.count - 2) && (int'(meas_count) <= e.count + 2),
                              meas_count, e.count);
                        check("busy_cycles", busy_cnt == e.cycles, busy_cnt, e.cycles);
                        $display("cal done: target=%0d code=%0d meas=%0d err=%0b busy=%0d",
                                 target, code, meas_count, cal_err, busy_cnt);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic wait_done(input int n);
        int k = 0;
        while (done_cnt < n && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < n) check("done_timeout", 1'b0, done_cnt, n);
    endtask

    task automatic run_cal(input int tgt);
        int d;
        d = done_cnt;
        @(negedge clk);
        target = CW'(tgt);
        start = 1'b1;
        sb.push_back(model(tgt));
        @(negedge clk);
        start = 1'b0;
        wait_done(d + 1);
        @(negedge clk);
    endtask

    initial begin
        int d;
        int k;
        int codes[5] = '{0, 5, 13, 20, 31};
        int widths[5] = '{0, 5, 13, 20, 26};

        // T1: reset values
        repeat (3) @(negedge clk);
        check("rst_trim", trim == 26'h0, trim, 0);
        check("rst_osc_reset", osc_reset == 1'b1, osc_reset, 1);
        check("rst_busy", busy == 1'b0, busy, 0);
        check("rst_done", done == 1'b0, done, 0);
        check("rst_code", code == 5'd0, code, 0);
        check("rst_meas", meas_count == '0, meas_count, 0);
        check("rst_err", cal_err == 1'b0, cal_err, 0);
        reset = 1'b0;
        s_reset = 1'b0;

        // Saturation with an 8-bit counter
        @(negedge clk);
        s_target = 8'd200;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        k = 0;
        while (!s_done && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check("sat_done", s_done == 1'b1, s_done, 1);
        check("sat_code", s_code == 5'd26, s_code, 26);
        check("sat_meas", s_meas == 8'hFF, s_meas, 255);
        check("sat_err", s_err == 1'b0, s_err, 0);
        $display("sat cal: code=%0d meas=%0d err=%0b", s_code, s_meas, s_err);

        // T2: manual decode, one-cycle latency
        manual_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            manual_code = 5'(codes[i]);
            @(negedge clk);
            check("manual_trim", trim == therm(widths[i]), trim, therm(widths[i]));
            $display("manual code=%0d trim=%h", codes[i], trim);
        end
        check("manual_osc_reset", osc_reset == 1'b0, osc_reset, 0);

        // manual_en and start together: manual wins
        manual_code = 5'd7;
        start = 1'b1;
        repeat (4) @(negedge clk);
        check("manual_prio_busy", busy == 1'b0, busy, 0);
        check("manual_prio_trim", trim == 26'h7F, trim, 26'h7F);
        start = 1'b0;
        manual_en = 1'b0;
        @(negedge clk);

        // T3-T5: nominal, too slow, too fast
        run_cal(100);
        run_cal(250);
        run_cal(5);

        // Mid-run reset during MEASURE aborts with no done
        @(negedge clk);
        target = CW'(100);
        start = 1'b1;
        sb.push_back(model(100));
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE + 60) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        check("abort_trim", trim == 26'h0, trim, 0);
        check("abort_osc_reset", osc_reset == 1'b1, osc_reset, 1);
        check("abort_busy", busy == 1'b0, busy, 0);
        check("abort_code", code == 5'd0, code, 0);
        reset = 1'b0;
        d = done_cnt;
        repeat (WINDOW * 2) @(negedge clk);
        check("abort_no_done", done_cnt == d, done_cnt, d);

        // T6: start pulsed while busy is ignored
        d = done_cnt;
        @(negedge clk);
        target = CW'(197 - 6 * 10);
        start = 1'b1;
        sb.push_back(model(197 - 6 * 10));
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        target = CW'(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d + 1);
        repeat (20) @(negedge clk);
        check("ignored_start_busy", busy == 1'b0, busy, 0);
        check("ignored_start_dones", done_cnt == d + 1, done_cnt, d + 1);

        // start held high re-triggers after DONE
        d = done_cnt;
        @(negedge clk);
        target = CW'(197 - 6 * 20);
        start = 1'b1;
        sb.push_back(model(197 - 6 * 20));
        sb.push_back(model(197 - 6 * 20));
        k = 0;
        while (!done && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("held_idle_busy", busy == 1'b0, busy, 0);
        @(negedge clk);
        check("held_rebusy", busy == 1'b1, busy, 1);
        start = 1'b0;
        wait_done(d + 2);
        @(negedge clk);

        // Randomized targets placed midway between adjacent code counts
        for (int i = 0; i < 4; i++) begin
            int c;
            c = int'($urandom_range(0, 25));
            run_cal(197 - 6 * c);
        end

        check("scoreboard_empty", sb.size() == 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
